// File: rtl/alu_iter_if.sv
// alu_iter_if
//   Handshake bundle between the decode/operand-read stage (master) and
//   alu_iter_unit (slave).
//   Issue side  : in_valid/in_ready with instr, rs1_val, rs2_val, imm.
//   Result side : out_valid/out_ready with result and illegal.
//   Parameter XLEN sets the operand/result width.
interface alu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, instr, rs1_val, rs2_val, imm, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, imm, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/alu_iter_unit.sv
// alu_iter_unit
//   Handshaked RV32I OP / OP-IMM execute unit, one instruction in flight.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : alu_iter_if.slave (issue handshake + operands, result handshake)
//   Parameters:
//     XLEN       : datapath width (power of two, >= 8)
//     SHIFT_STEP : bits shifted per cycle in iterative mode (power of two, 1..XLEN/2)
//   Build option:
//     ALU_ITER_SHIFT_EN defined   -> shifts iterate in the SHIFT state
//     ALU_ITER_SHIFT_EN undefined -> barrel shifter, single-cycle for everything
//
//   state | meaning
//   IDLE  | waiting for an instruction, in_ready=1
//   SHIFT | iterative shift in progress, SHIFT_STEP bits per cycle
//   DONE  | result/illegal held with out_valid=1 until out_ready
module alu_iter_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_iter_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
        $error("alu_iter_unit: XLEN must be a power of two >= 8");
    end
    if (SHIFT_STEP < 1 || SHIFT_STEP > XLEN / 2 || (SHIFT_STEP & (SHIFT_STEP - 1)) != 0) begin : g_bad_step
        $error("alu_iter_unit: SHIFT_STEP must be a power of two in 1..XLEN/2");
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    logic [6:0]      w_opcode, w_funct7;
    logic [2:0]      w_funct3;
    logic            w_b30, w_is_op, w_is_imm, w_legal;
    logic [XLEN-1:0] w_a, w_b, w_alu;
    logic [SW-1:0]   w_shamt;
    logic            w_in_ready, w_out_valid, w_accept;
    logic            w_go_shift, w_last;

    // Register-address fields play no part in execution.
    logic w_unused_fields;
    assign w_unused_fields = &{1'b0, bus.instr[24:15], bus.instr[11:7]};

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];
    assign w_b30    = bus.instr[30];
    assign w_is_op  = (w_opcode == OPC_OP);
    assign w_is_imm = (w_opcode == OPC_IMM);
    assign w_a      = bus.rs1_val;
    assign w_b      = w_is_op ? bus.rs2_val : bus.imm;
    assign w_shamt  = w_b[SW-1:0];

    always_comb begin
        w_legal = 1'b0;
        if (w_is_op) begin
            w_legal = (w_funct7 == 7'b0000000) ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
        end else if (w_is_imm) begin
            case (w_funct3)
                3'b001:  w_legal = (w_funct7 == 7'b0000000);
                3'b101:  w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                default: w_legal = 1'b1;
            endcase
        end
    end

    // In the iterative build the shift cases only cover shamt=0 (result = rs1);
    // nonzero amounts are produced by the SHIFT state.
    always_comb begin
        w_alu = '0;
        case (w_funct3)
            3'b000:  w_alu = (w_is_op && w_b30) ? (w_a - w_b) : (w_a + w_b);
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            3'b100:  w_alu = w_a ^ w_b;
            3'b110:  w_alu = w_a | w_b;
            3'b111:  w_alu = w_a & w_b;
`ifdef ALU_ITER_SHIFT_EN
            3'b001:  w_alu = w_a;
            3'b101:  w_alu = w_a;
`else
            3'b001:  w_alu = w_a << w_shamt;
            3'b101: begin
                if (w_b30) w_alu = $signed(w_a) >>> w_shamt;
                else       w_alu = w_a >> w_shamt;
            end
`endif
            default: w_alu = '0;
        endcase
        if (!w_legal) w_alu = '0;
    end

`ifdef ALU_ITER_SHIFT_EN
    localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

    logic [XLEN-1:0] r_work, w_work_sh;
    logic [SW-1:0]   r_cnt, w_step;
    logic            r_left, r_arith;

    assign w_go_shift = w_legal && (w_funct3 == 3'b001 || w_funct3 == 3'b101) && (w_shamt != '0);
    assign w_step     = (r_cnt > STEP) ? STEP : r_cnt;
    assign w_last     = (r_cnt == w_step);

    always_comb begin
        w_work_sh = r_work >> w_step;
        if (r_left)       w_work_sh = r_work << w_step;
        else if (r_arith) w_work_sh = $signed(r_work) >>> w_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (w_accept && w_go_shift) begin
            r_work  <= w_a;
            r_cnt   <= w_shamt;
            r_left  <= (w_funct3 == 3'b001);
            r_arith <= w_b30;
        end else if (r_state == S_SHIFT) begin
            r_work  <= w_work_sh;
            r_cnt   <= r_cnt - w_step;
        end
    end
`else
    assign w_go_shift = 1'b0;
    assign w_last     = 1'b1;
`endif

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = 1'b1;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_in_ready && bus.in_valid) begin
            w_accept = 1'b1;
            w_next   = w_go_shift ? S_SHIFT : S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_result  <= w_alu;
                r_illegal <= !w_legal;
            end
`ifdef ALU_ITER_SHIFT_EN
            else if (r_state == S_SHIFT && w_last) begin
                r_result <= w_work_sh;
            end
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.illegal   = r_illegal;
endmodule
